// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline front-end hazard controller.
package pipeline_hazard_ctrl_pkg;

    // Controller FSM: normal issue, or squashing wrong-path fetch slots.
    typedef enum logic {
        S_RUN   = 1'b0,
        S_FLUSH = 1'b1
    } hazard_state_t;

    // X31 reads as zero (XZR), so a write to it never feeds a consumer.
    localparam logic [4:0] XZR_ADDR = 5'd31;

    localparam int FLUSH_DEPTH_DEFAULT = 2;

    // True when a decode source operand is live and names the given register.
    function automatic logic src_matches(input logic       uses,
                                         input logic [4:0] src_addr,
                                         input logic [4:0] dst_addr);
        return uses && (src_addr == dst_addr);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Next count value, held at the ceiling instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (value == CNT_MAX) begin
            return value;
        end
        return value + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Counter register with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc) begin
            count <= sat_inc(count);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Front-end sequencing for the 5-stage LEGv8 pipeline: load-use and flag
// stalls, taken-branch squash, memory-busy freeze, and perf counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_DEPTH = FLUSH_DEPTH_DEFAULT,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rn_addr,
    input  logic [4:0]       id_rm_addr,
    input  logic             id_uses_rn,
    input  logic             id_uses_rm,
    input  logic             id_is_bcond,
    input  logic             ex_MemRead,
    input  logic             ex_RegWrite,
    input  logic [4:0]       ex_reg_write_addr,
    input  logic             ex_set_flags,
    input  logic             ex_branch_taken,
    input  logic             mem_stall,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             rf_ex_bubble,
    output logic             pipe_en,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    // Slots still to squash after the branch cycle itself.
    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_DEPTH - 1);
    localparam bit         MULTI_FLUSH  = (FLUSH_DEPTH > 1);

    hazard_state_t state, state_n;
    logic [2:0]    fcnt, fcnt_n;

    logic load_use;
    logic flag_haz;
    logic stall;
    logic stall_inc;
    logic flush_inc;

    // Hazard detection against the instruction currently in EX.
    always_comb begin
        load_use = id_valid && ex_MemRead && ex_RegWrite &&
                   (ex_reg_write_addr != XZR_ADDR) &&
                   (src_matches(id_uses_rn, id_rn_addr, ex_reg_write_addr) ||
                    src_matches(id_uses_rm, id_rm_addr, ex_reg_write_addr));
        flag_haz = id_valid && id_is_bcond && ex_set_flags;
        stall    = load_use || flag_haz;
    end

    // State and flush-slot counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_RUN;
            fcnt  <= 3'd0;
        end else begin
            state <= state_n;
            fcnt  <= fcnt_n;
        end
    end

    // Next state and same-cycle pipeline enables; priority is
    // reset > mem_stall > branch > stall > normal issue.
    always_comb begin
        state_n      = state;
        fcnt_n       = fcnt;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        rf_ex_bubble = 1'b0;
        pipe_en      = 1'b1;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;

        if (reset) begin
            // Hold fetch and drain NOPs into decode/EX while resetting.
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            if_id_flush  = 1'b1;
            rf_ex_bubble = 1'b1;
            state_n      = S_RUN;
            fcnt_n       = 3'd0;
        end else if (mem_stall) begin
            // Whole-pipe freeze: nothing moves, nothing is squashed.
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            pipe_en  = 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    if (ex_branch_taken) begin
                        if_id_flush  = 1'b1;
                        rf_ex_bubble = 1'b1;
                        flush_inc    = 1'b1;
                        if (MULTI_FLUSH) begin
                            state_n = S_FLUSH;
                            fcnt_n  = FLUSH_RELOAD;
                        end
                    end else if (stall) begin
                        // One bubble is enough: the producer leaves EX next cycle.
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        rf_ex_bubble = 1'b1;
                        stall_inc    = 1'b1;
                    end
                end
                S_FLUSH: begin
                    // Decode holds a wrong-path instruction, so its hazards are moot.
                    if_id_flush  = 1'b1;
                    rf_ex_bubble = 1'b1;
                    if (ex_branch_taken) begin
                        flush_inc = 1'b1;
                        if (MULTI_FLUSH) begin
                            fcnt_n = FLUSH_RELOAD;
                        end else begin
                            state_n = S_RUN;
                            fcnt_n  = 3'd0;
                        end
                    end else if (fcnt <= 3'd1) begin
                        state_n = S_RUN;
                        fcnt_n  = 3'd0;
                    end else begin
                        fcnt_n = fcnt - 3'd1;
                    end
                end
                default: begin
                    state_n = S_RUN;
                    fcnt_n  = 3'd0;
                end
            endcase
        end
    end

    assign ctrl_state = {1'b0, state};

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cycles)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_events)
    );

endmodule
